// File: rtl/nibble_serial_add_ctrl.sv
// Sequencer for a WIDTH-bit add/subtract built from one 4-bit ripple slice,
// processing one nibble per clock, LSB nibble first, carry registered between.
module nibble_serial_add_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int N     = WIDTH / 4;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] a_r, a_s;
  logic [WIDTH-1:0] b_r, b_s;
  logic             carry_r, carry_s;
  logic [IDX_W-1:0] idx_r, idx_s;
  logic [WIDTH-1:0] sum_r, sum_s;
  logic             cout_r, cout_s;
  logic             ovf_r, ovf_s;
  logic             busy_r, busy_s;
  logic             done_r, done_s;
  logic [4:0]       slice_s;
  logic [IDX_W+1:0] sh_s;
  logic [WIDTH-1:0] sum_nib_s;

  function automatic logic [4:0] slice_add(input logic [3:0] x, input logic [3:0] y,
                                           input logic c);
    slice_add = {1'b0, x} + {1'b0, y} + {4'b0000, c};
  endfunction

  // Operands shift right each step, so the active nibble is always [3:0]
  // and on the last step bit 3 is the operand MSB used for overflow.
  always_comb begin
    state_s   = state_r;
    a_s       = a_r;
    b_s       = b_r;
    carry_s   = carry_r;
    idx_s     = idx_r;
    sum_s     = sum_r;
    cout_s    = cout_r;
    ovf_s     = ovf_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    slice_s   = slice_add(a_r[3:0], b_r[3:0], carry_r);
    sh_s      = {idx_r, 2'b00};
    sum_nib_s = WIDTH'(slice_s[3:0]) << sh_s;
    case (state_r)
      IDLE: begin
        if (start) begin
          a_s     = a;
          b_s     = sub ? ~b : b;
          carry_s = sub ? 1'b1 : cin;
          idx_s   = '0;
          sum_s   = '0;
          busy_s  = 1'b1;
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        a_s     = a_r >> 4;
        b_s     = b_r >> 4;
        carry_s = slice_s[4];
        sum_s   = sum_r | sum_nib_s;
        idx_s   = idx_r + 1'b1;
        if (idx_r == IDX_LAST) begin
          cout_s  = slice_s[4];
          ovf_s   = (a_r[3] == b_r[3]) && (slice_s[3] != a_r[3]);
          done_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
      default: begin
        busy_s  = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      a_r     <= a_s;
      b_r     <= b_s;
      carry_r <= carry_s;
      idx_r   <= idx_s;
      sum_r   <= sum_s;
      cout_r  <= cout_s;
      ovf_r   <= ovf_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign busy = busy_r;
  assign done = done_r;
  assign sum  = sum_r;
  assign cout = cout_r;
  assign ovf  = ovf_r;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl (WIDTH=16) with hand-computed
// expectations checked by immediate assertions.
module tb_nibble_serial_add_ctrl;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int n_cmp;
  int n_fail;

  nibble_serial_add_ctrl #(.WIDTH(16)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout),
    .ovf  (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one op from IDLE and check latency and results.
  task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                        input logic subv, input logic cinv, input logic scramble,
                        input logic [15:0] es, input logic ec, input logic eo);
    int k;
    a = av; b = bv; sub = subv; cin = cinv; start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_busy_acc"}, 32'(busy), 32'd1);
    k = 0;
    while (k < 10) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom); cin = ~cin; sub = ~sub;
      end
      tick();
      k++;
      if (done) break;
    end
    check({tag, "_latency"}, 32'(k), 32'd4);
    check({tag, "_sum"}, 32'(sum), 32'(es));
    check({tag, "_cout"}, 32'(cout), 32'(ec));
    check({tag, "_ovf"}, 32'(ovf), 32'(eo));
    tick();
    check({tag, "_done_clr"}, 32'(done), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dones;
    logic exp_busy;
    logic exp_done;
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0; start = 1'b0; sub = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum",  32'(sum),  32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    check("rst_ovf",  32'(ovf),  32'd0);

    run_op("t1_ffff_p1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t2_7fff_p1", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("t2_sub_eq",  16'h1234, 16'h1234, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("t3_0_m1",    16'h0000, 16'h0001, 1'b1, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0);
    run_op("t3_8000_m1", 16'h8000, 16'h0001, 1'b1, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1);

    // Test 4: start held for 10 edges -> accepts at edges 0 and 6.
    a = 16'h0001; b = 16'h0002; sub = 1'b0; cin = 1'b0; start = 1'b1;
    dones = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (i == 9) start = 1'b0;
      exp_busy = (i <= 4) || (i >= 6 && i <= 10);
      exp_done = (i == 4) || (i == 10);
      check($sformatf("t4_busy_e%0d", i), 32'(busy), 32'(exp_busy));
      check($sformatf("t4_done_e%0d", i), 32'(done), 32'(exp_done));
      if (done) begin
        dones++;
        check($sformatf("t4_sum_e%0d", i), 32'(sum), 32'h0003);
      end
    end
    check("t4_done_count", 32'(dones), 32'd2);

    // Test 5: reset lands on the 2nd RUN edge.
    a = 16'h1111; b = 16'h1111; sub = 1'b0; cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("t5_partial_sum", 32'(sum), 32'h0002);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_busy", 32'(busy), 32'd0);
    check("t5_done", 32'(done), 32'd0);
    check("t5_sum",  32'(sum),  32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check($sformatf("t5_nodone_%0d", i), 32'(done), 32'd0);
    end
    run_op("t5_after", 16'h0005, 16'h0003, 1'b1, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b0);

    // Test 6: inputs scrambled every cycle during RUN.
    run_op("t6_scramble", 16'h0F0F, 16'h00F1, 1'b0, 1'b1, 1'b1, 16'h1001, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
